w_frame_loader: RTL and testbench

Serial front end for the photonic switch controller. It receives 16-bit command frames from the host over a 3-wire serial link (sclk, sdi, cs_n), oversampled in the core clock domain. It range-checks the 13-bit period word W and presents it to the decoder/PWM top level together with the reset/load pulse sequence that top level expects. It sits directly upstream of the decoder and drives its W, reset and load inputs.

---
 rtl/w_frame_loader_pkg.sv | 24 ++
 rtl/w_frame_loader_if.sv | 25 ++
 rtl/w_frame_loader_sync2.sv | 21 ++
 rtl/w_frame_loader.sv | 141 ++++++++++++++
 tb/tb_w_frame_loader.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/w_frame_loader_pkg.sv
// Shared definitions for the photonic-switch serial frame loader.
// Build option LOADER_PARITY_EN adds a trailing even-parity bit to each frame.
package w_loader_pkg;

    localparam int W_BITS = 13;

    localparam logic [2:0] CMD_WRITE  = 3'b001;
    localparam logic [2:0] CMD_LOAD   = 3'b010;
    localparam logic [2:0] CMD_CLRERR = 3'b011;

`ifdef LOADER_PARITY_EN
    localparam int FRAME_BITS = 17;
`else
    localparam int FRAME_BITS = 16;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_CHECK,
        ST_APPLY
    } state_t;

endpackage

// File: rtl/w_frame_loader_if.sv
// Host serial link plus the decoder-side outputs of the frame loader.
interface w_frame_loader_if;
    import w_loader_pkg::*;

    logic              sclk;
    logic              sdi;
    logic              cs_n;
    logic [W_BITS-1:0] W;
    logic              dec_reset;
    logic              load;
    logic              busy;
    logic              err;
    logic [7:0]        frame_cnt;

    modport master (
        output sclk, sdi, cs_n,
        input  W, dec_reset, load, busy, err, frame_cnt
    );

    modport slave (
        input  sclk, sdi, cs_n,
        output W, dec_reset, load, busy, err, frame_cnt
    );

endinterface

// File: rtl/w_frame_loader_sync2.sv
// Two-flop synchronizer; resets to the idle-high level of the serial lines.
module sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/w_frame_loader.sv
// Serial command-frame receiver driving W, dec_reset and load of the decoder.
// Define LOADER_PARITY_EN for 17-bit frames carrying an even-parity bit.
module w_frame_loader
    import w_loader_pkg::*;
#(
    parameter logic [W_BITS-1:0] W_INIT     = 13'd2,
    parameter logic [W_BITS-1:0] W_MIN      = 13'd2,
    parameter logic [W_BITS-1:0] W_MAX      = 13'd6401,
    parameter int unsigned       RST_CYCLES = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    w_frame_loader_if.slave  bus
);

    logic sclk_s, sdi_s, cs_s, sclk_d, sclk_rise;

    state_t state_q, state_nxt;

    logic [FRAME_BITS-1:0] shreg;
    logic [4:0]            bit_cnt;
    logic [3:0]            apply_cnt;
    logic [W_BITS-1:0]     w_q;
    logic                  dec_reset_q, load_q, err_q;
    logic [7:0]            cnt_q;

    logic [15:0]       payload;
    logic [2:0]        cmd;
    logic [W_BITS-1:0] data;
    logic              frame_ok, write_ok, accept, clr_ok;

    logic enter_shift, enter_apply, apply_done;
    logic err_set, err_clr, w_load, dec_reset_nxt, load_nxt, busy;

    function automatic logic parity_good(input logic [FRAME_BITS-1:0] f);
`ifdef LOADER_PARITY_EN
        return ~^f;
`else
        return 1'b1;
`endif
    endfunction

    sync2 u_sync_sclk (.clk(clk), .reset(reset), .d(bus.sclk), .q(sclk_s));
    sync2 u_sync_sdi  (.clk(clk), .reset(reset), .d(bus.sdi),  .q(sdi_s));
    sync2 u_sync_cs   (.clk(clk), .reset(reset), .d(bus.cs_n), .q(cs_s));

    // Edge flop runs regardless of en, so rises during en=0 are dropped
    always_ff @(posedge clk) begin
        if (!reset) sclk_d <= 1'b1;
        else        sclk_d <= sclk_s;
    end

    assign sclk_rise = sclk_s & ~sclk_d;

    assign payload  = shreg[FRAME_BITS-1 -: 16];
    assign cmd      = payload[15:13];
    assign data     = payload[12:0];
    assign frame_ok = (bit_cnt == 5'(FRAME_BITS)) && parity_good(shreg);
    assign write_ok = (cmd == CMD_WRITE) && (data >= W_MIN) && (data <= W_MAX);
    assign accept   = frame_ok && (write_ok || (cmd == CMD_LOAD));
    assign clr_ok   = frame_ok && (cmd == CMD_CLRERR);

    always_ff @(posedge clk) begin
        if (!reset)  state_q <= ST_IDLE;
        else if (en) state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE:  if (!cs_s) state_nxt = ST_SHIFT;
            ST_SHIFT: if (cs_s)  state_nxt = ST_CHECK;
            ST_CHECK: state_nxt = accept ? ST_APPLY : ST_IDLE;
            ST_APPLY: if (apply_cnt == 4'd0) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        enter_shift   = (state_q == ST_IDLE)  && (state_nxt == ST_SHIFT);
        enter_apply   = (state_q == ST_CHECK) && (state_nxt == ST_APPLY);
        apply_done    = (state_q == ST_APPLY) && (state_nxt == ST_IDLE);
        err_set       = (state_q == ST_CHECK) && !accept && !clr_ok;
        err_clr       = ((state_q == ST_CHECK) && clr_ok) || apply_done;
        w_load        = enter_apply && (cmd == CMD_WRITE);
        dec_reset_nxt = (state_nxt == ST_APPLY);
        load_nxt      = enter_apply && (cmd == CMD_LOAD);
        busy          = (state_q != ST_IDLE);
    end

    // Frame capture
    always_ff @(posedge clk) begin
        if (en) begin
            if (enter_shift)
                shreg <= '0;
            else if ((state_q == ST_SHIFT) && sclk_rise)
                shreg <= {shreg[FRAME_BITS-2:0], sdi_s};
        end
    end

    // Control and decoder-facing registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            bit_cnt     <= 5'd0;
            apply_cnt   <= 4'd0;
            w_q         <= W_INIT;
            dec_reset_q <= 1'b1;
            load_q      <= 1'b1;
            err_q       <= 1'b0;
            cnt_q       <= 8'd0;
        end else if (en) begin
            if (enter_shift)
                bit_cnt <= 5'd0;
            else if ((state_q == ST_SHIFT) && sclk_rise && (bit_cnt != 5'd31))
                bit_cnt <= bit_cnt + 5'd1;

            if (enter_apply)
                apply_cnt <= 4'(RST_CYCLES - 1);
            else if ((state_q == ST_APPLY) && (apply_cnt != 4'd0))
                apply_cnt <= apply_cnt - 4'd1;

            if (w_load) w_q <= data;
            dec_reset_q <= dec_reset_nxt;
            load_q      <= load_nxt;

            if (err_set)      err_q <= 1'b1;
            else if (err_clr) err_q <= 1'b0;

            if (apply_done) cnt_q <= cnt_q + 8'd1;
        end
    end

    assign bus.W         = w_q;
    assign bus.dec_reset = dec_reset_q;
    assign bus.load      = load_q;
    assign bus.busy      = busy;
    assign bus.err       = err_q;
    assign bus.frame_cnt = cnt_q;

endmodule

// File: tb/tb_w_frame_loader.sv
// Scoreboard bench for w_frame_loader: expected frame outcomes queued at drive time.
`timescale 1ns/1ps
module tb_w_frame_loader;

    logic clk = 1'b0;
    logic reset;
    logic en;

    w_frame_loader_if bus();

    w_frame_loader dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [12:0] w;
        logic        err;
        logic [7:0]  cnt;
        int          pulse;
        int          loads;
    } exp_t;

    exp_t sb[$];

    logic [12:0] m_w;
    logic        m_err;
    logic [7:0]  m_cnt;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef LOADER_PARITY_EN
    localparam int FB = 17;
`else
    localparam int FB = 16;
`endif

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference behaviour of one frame, applied to the bench's own state copy
    task automatic model_push(input logic [15:0] payload, input logic bad_par, input int nbits);
        exp_t        e;
        logic        ok;
        logic [2:0]  c;
        logic [12:0] d;
        ok = (nbits == FB) && !bad_par;
        c  = payload[15:13];
        d  = payload[12:0];
        e.pulse = 0;
        e.loads = 0;
        if (ok && c == 3'b001 && d >= 13'd2 && d <= 13'd6401) begin
            m_w = d; m_err = 1'b0; m_cnt = m_cnt + 8'd1; e.pulse = 3;
        end else if (ok && c == 3'b010) begin
            m_err = 1'b0; m_cnt = m_cnt + 8'd1; e.pulse = 3; e.loads = 1;
        end else if (ok && c == 3'b011) begin
            m_err = 1'b0;
        end else begin
            m_err = 1'b1;
        end
        e.w = m_w; e.err = m_err; e.cnt = m_cnt;
        sb.push_back(e);
    endtask

    task automatic drive_frame(input logic [15:0] payload, input logic bad_par, input int nbits);
        logic [16:0] v;
`ifdef LOADER_PARITY_EN
        v = {payload, (^payload) ^ bad_par};
`else
        v = {1'b0, payload};
`endif
        @(negedge clk);
        bus.cs_n = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            bus.sclk = 1'b0;
            bus.sdi  = v[FB-1-i];
            repeat (5) @(negedge clk);
            bus.sclk = 1'b1;
            repeat (5) @(negedge clk);
        end
        repeat (2) @(negedge clk);
        bus.cs_n = 1'b1;
    endtask

    task automatic check_frame(input string tag);
        int   dr, ld, first_ld;
        logic done;
        exp_t e;
        dr = 0; ld = 0; first_ld = 0; done = 1'b0;
        for (int cyc = 0; cyc < 80 && !done; cyc++) begin
            @(negedge clk);
            if (bus.dec_reset) dr++;
            if (bus.load) begin
                ld++;
                if (bus.dec_reset && dr == 1) first_ld++;
            end
            if (!bus.busy && cyc >= 2) done = 1'b1;
        end
        if (!done) check_val({tag, "_timeout"}, 32'd0, 32'd1);
        if (sb.size() == 0) begin
            check_val({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check_val({tag, "_W"},         32'(bus.W),         32'(e.w));
            check_val({tag, "_err"},       32'(bus.err),       32'(e.err));
            check_val({tag, "_frame_cnt"}, 32'(bus.frame_cnt), 32'(e.cnt));
            check_val({tag, "_rst_width"}, 32'(dr),            32'(e.pulse));
            check_val({tag, "_load_cnt"},  32'(ld),            32'(e.loads));
            check_val({tag, "_load_1st"},  32'(first_ld),      32'(e.loads));
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic frame(input string tag, input logic [15:0] payload, input logic bad_par, input int nbits);
        model_push(payload, bad_par, nbits);
        drive_frame(payload, bad_par, nbits);
        check_frame(tag);
    endtask

    initial begin
        logic seen;
        reset    = 1'b0;
        en       = 1'b1;
        bus.cs_n = 1'b1;
        bus.sclk = 1'b1;
        bus.sdi  = 1'b0;
        m_w = 13'd2; m_err = 1'b0; m_cnt = 8'd0;

        repeat (3) @(posedge clk);
        #1;
        check_val("rst_W",         32'(bus.W),         32'd2);
        check_val("rst_dec_reset", 32'(bus.dec_reset), 32'd1);
        check_val("rst_load",      32'(bus.load),      32'd1);
        check_val("rst_busy",      32'(bus.busy),      32'd0);
        check_val("rst_err",       32'(bus.err),       32'd0);
        check_val("rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_val("rel_dec_reset", 32'(bus.dec_reset), 32'd0);
        check_val("rel_load",      32'(bus.load),      32'd0);
        repeat (4) @(negedge clk);

        frame("wr_max",    16'h3901, 1'b0, FB);
        frame("wr_low",    16'h2001, 1'b0, FB);
        frame("abort9",    16'h2BB8, 1'b0, 9);
        frame("wr_3000",   16'h2BB8, 1'b0, FB);
`ifdef LOADER_PARITY_EN
        frame("par_bad",   16'h3901, 1'b1, FB);
        frame("par_good",  16'h3901, 1'b0, FB);
`endif
        frame("illegal",   16'hE000, 1'b0, FB);
        frame("clrerr",    16'h6000, 1'b0, FB);
        frame("ld",        16'h4000, 1'b0, FB);

        // Reset in the middle of the APPLY pulse
        drive_frame(16'h2BB8, 1'b0, FB);
        seen = 1'b0;
        for (int cyc = 0; cyc < 80 && !seen; cyc++) begin
            @(negedge clk);
            if (bus.dec_reset) seen = 1'b1;
        end
        if (!seen) check_val("midrst_timeout", 32'd0, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_val("midrst_W",         32'(bus.W),         32'd2);
        check_val("midrst_dec_reset", 32'(bus.dec_reset), 32'd1);
        check_val("midrst_load",      32'(bus.load),      32'd1);
        check_val("midrst_busy",      32'(bus.busy),      32'd0);
        check_val("midrst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_val("midrel_dec_reset", 32'(bus.dec_reset), 32'd0);
        m_w = 13'd2; m_err = 1'b0; m_cnt = 8'd0;
        repeat (4) @(negedge clk);

        frame("post_rst", 16'h3901, 1'b0, FB);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "bench time limit expired");
    end

endmodule
